// File: rtl/font_pkg.sv
// Shared constants and types for the font loading path: staging-buffer
// geometry, character-generator SPRAM geometry and the loader state encoding.
package font_pkg;

  localparam int         FONT_WORDS     = 256;
  localparam int         FONT_AW        = 8;
  localparam int         SPRAM_AW       = 14;
  localparam logic [3:0] SPRAM_MASK_ALL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

endpackage

// File: rtl/font_loader_if.sv
// Bus bundle between the font loader, the staging buffer read port and the
// shared character-generator SPRAM. The master side is the loader.
interface font_loader_if #(
  parameter int AW = font_pkg::SPRAM_AW
);

  logic          fb_rd;
  logic [7:0]    fb_rd_addr;
  logic [15:0]   fb_rd_data;
  logic          spram_req;
  logic          spram_gnt;
  logic          spram_we;
  logic [AW-1:0] spram_addr;
  logic [15:0]   spram_wdata;
  logic [3:0]    spram_maskwe;

  modport master (
    output fb_rd,
    output fb_rd_addr,
    input  fb_rd_data,
    output spram_req,
    input  spram_gnt,
    output spram_we,
    output spram_addr,
    output spram_wdata,
    output spram_maskwe
  );

  modport slave (
    input  fb_rd,
    input  fb_rd_addr,
    output fb_rd_data,
    input  spram_req,
    output spram_gnt,
    input  spram_we,
    input  spram_addr,
    input  spram_wdata,
    input  spram_maskwe
  );

endinterface

// File: rtl/font_loader.sv
// Copies COUNT words from the font staging buffer into character-generator
// SPRAM starting at a caller-supplied base address. SPRAM is shared with the
// character generator, so every read and write is gated by the grant; while
// the grant is low nothing advances and the buffer holds its last read data,
// which keeps the one-word read-to-write pipeline intact across stalls.
module font_loader
  import font_pkg::*;
#(
  parameter int COUNT    = FONT_WORDS,
  parameter int SPRAM_AW = font_pkg::SPRAM_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SPRAM_AW-1:0] base,
  output logic                busy,
  output logic                done,
  font_loader_if.master       bus
);

  localparam logic [8:0] COUNT_W = 9'(COUNT);

  state_t              state;
  state_t              state_nx;
  logic [SPRAM_AW-1:0] base_q;
  logic [8:0]          rd_idx;
  logic [8:0]          wr_idx;
  logic                pend;
  logic                rd_fire;
  logic                wr_fire;
  logic                req;

  // Next-state and strobe decode; reads and writes only fire while granted,
  // and the final write moves straight to the one-cycle DONE state.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    req      = 1'b0;
    rd_fire  = 1'b0;
    wr_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = XFER;
      end
      XFER: begin
        busy    = 1'b1;
        req     = 1'b1;
        rd_fire = bus.spram_gnt && (rd_idx < COUNT_W);
        wr_fire = bus.spram_gnt && pend;
        if (wr_fire && (wr_idx == COUNT_W - 9'd1)) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.spram_req    = req;
  assign bus.fb_rd        = rd_fire;
  assign bus.fb_rd_addr   = rd_idx[7:0];
  assign bus.spram_we     = wr_fire;
  assign bus.spram_addr   = base_q + SPRAM_AW'(wr_idx);
  assign bus.spram_wdata  = bus.fb_rd_data;
  assign bus.spram_maskwe = SPRAM_MASK_ALL;

  // State register plus read/write counters; pend marks that the buffer
  // output holds a word not yet written, and it freezes while ungranted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      base_q <= '0;
      rd_idx <= '0;
      wr_idx <= '0;
      pend   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        base_q <= base;
        rd_idx <= '0;
        wr_idx <= '0;
        pend   <= 1'b0;
      end
      if (rd_fire) rd_idx <= rd_idx + 9'd1;
      if (wr_fire) wr_idx <= wr_idx + 9'd1;
      if (state == XFER && bus.spram_gnt) pend <= rd_fire;
    end
  end

endmodule

// File: tb/tb_font_loader.sv
// Bench for font_loader: a behavioural staging buffer feeds two loaders
// (full 256-word and 4-word), writes are collected and compared with the
// expected (base+i mod 2^14, word[i]) sequence and cycle-count rules.
module tb_font_loader;
  import font_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        start4;
  logic [13:0] base;
  logic        gnt;
  logic        busy, done, busy4, done4;

  int checks   = 0;
  int failures = 0;

  font_loader_if #(.AW(14)) bus ();
  font_loader_if #(.AW(14)) bus4 ();

  font_loader #(.COUNT(256), .SPRAM_AW(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base),
    .busy(busy), .done(done), .bus(bus.master)
  );

  font_loader #(.COUNT(4), .SPRAM_AW(14)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .base(base),
    .busy(busy4), .done(done4), .bus(bus4.master)
  );

  always #5 clk = ~clk;

  assign bus.spram_gnt  = gnt;
  assign bus4.spram_gnt = gnt;

  // Staging buffer: registered read, output held while not reading.
  logic [15:0] mem [256];
  logic [15:0] rd_q  = 16'h0;
  logic [15:0] rd_q4 = 16'h0;
  always @(posedge clk) begin
    if (bus.fb_rd)  rd_q  <= mem[bus.fb_rd_addr];
    if (bus4.fb_rd) rd_q4 <= mem[bus4.fb_rd_addr];
  end
  assign bus.fb_rd_data  = rd_q;
  assign bus4.fb_rd_data = rd_q4;

  logic [13:0] wa[$];
  logic [15:0] wd[$];
  int          wc[$];
  int done_cyc, done_cnt, busy_bad, we_nogt, rd_oob, lows, late_bad;

  function automatic bit gnt_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ((c - 1) % 5) < 3;
      2:       return c > 10;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  function automatic int order_errors(input logic [13:0] b);
    int bad = 0;
    for (int i = 0; i < wa.size(); i++) begin
      logic [13:0] ea;
      ea = 14'((int'(b) + i) % 16384);
      if (wa[i] !== ea || wd[i] !== mem[i]) bad++;
    end
    return bad;
  endfunction

  function automatic int first_wc();
    return (wc.size() > 0) ? wc[0] : -1;
  endfunction

  function automatic int last_wc();
    return (wc.size() > 0) ? wc[wc.size()-1] : -1;
  endfunction

  // Pulses start, drives the grant pattern and records every observed write.
  task automatic run_xfer(input bit sel, input logic [13:0] b, input int mode,
                          input int extra_at, input int abort_n, input int cnt);
    logic we, rd, req, bsy, dn;
    logic [13:0] ad;
    logic [15:0] dt;
    logic [7:0]  ra;
    wa.delete(); wd.delete(); wc.delete();
    done_cyc = -1; done_cnt = 0; busy_bad = 0; we_nogt = 0;
    rd_oob = 0; lows = 0; late_bad = 0;
    @(posedge clk); #1;
    base = b;
    if (sel) start4 = 1'b1; else start = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      @(posedge clk); #1;
      start  = !sel && (c == extra_at);
      start4 = sel && (c == extra_at);
      base   = (c == extra_at) ? 14'h2000 : b;
      gnt    = gnt_for(mode, c);
      #1;
      if (sel) begin
        we = bus4.spram_we; rd = bus4.fb_rd; req = bus4.spram_req;
        ad = bus4.spram_addr; dt = bus4.spram_wdata; ra = bus4.fb_rd_addr;
        bsy = busy4; dn = done4;
      end else begin
        we = bus.spram_we; rd = bus.fb_rd; req = bus.spram_req;
        ad = bus.spram_addr; dt = bus.spram_wdata; ra = bus.fb_rd_addr;
        bsy = busy; dn = done;
      end
      if (dn) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end else if (done_cyc < 0 && !gnt) begin
        lows++;
      end
      if (we && !gnt) we_nogt++;
      if (rd && int'(ra) >= cnt) rd_oob++;
      if (we) begin wa.push_back(ad); wd.push_back(dt); wc.push_back(c); end
      if (done_cyc < 0 || c == done_cyc) begin
        if (bsy !== 1'b1) busy_bad++;
      end else if (bsy !== 1'b0) begin
        busy_bad++;
      end
      if (mode == 2 && c <= 10 && (req !== 1'b1 || rd !== 1'b0 || we !== 1'b0)) late_bad++;
      if (abort_n > 0 && wa.size() == abort_n) break;
      if (done_cyc > 0 && c >= done_cyc + 3) break;
    end
    start = 1'b0; start4 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0; base = 14'h0; gnt = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (bus.fb_rd !== 1'b0) begin failures++; $display("FAIL reset_fb_rd: got %b want 0", bus.fb_rd); end
    checks++; if (bus.spram_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", bus.spram_req); end
    checks++; if (bus.spram_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", bus.spram_we); end
    checks++; if (bus.fb_rd_addr !== 8'h0) begin failures++; $display("FAIL reset_rd_addr: got %h want 00", bus.fb_rd_addr); end
    checks++; if (bus.spram_addr !== 14'h0) begin failures++; $display("FAIL reset_spram_addr: got %h want 0000", bus.spram_addr); end
    checks++; if (bus.spram_maskwe !== 4'hF) begin failures++; $display("FAIL reset_maskwe: got %h want f", bus.spram_maskwe); end
    rst_n = 1'b1;
  endtask

  task automatic test_full_load();
    int bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hA500 + 16'(i);
    run_xfer(1'b0, 14'h0100, 0, 0, 0, 256);
    for (int i = 1; i < wc.size(); i++) if (wc[i] != wc[0] + i) bad++;
    checks++; if (wa.size() !== 256) begin failures++; $display("FAIL full_count: got %0d want 256", wa.size()); end
    checks++; if (order_errors(14'h0100) !== 0) begin failures++; $display("FAIL full_order: got %0d bad words want 0", order_errors(14'h0100)); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL full_consecutive: got %0d gaps want 0", bad); end
    checks++; if (first_wc() !== 2) begin failures++; $display("FAIL full_first_write: got cycle %0d want 2", first_wc()); end
    checks++; if (done_cyc !== 258) begin failures++; $display("FAIL full_done_cycle: got %0d want 258", done_cyc); end
    checks++; if (done_cyc !== last_wc() + 1) begin failures++; $display("FAIL full_done_after_last: got %0d want %0d", done_cyc, last_wc() + 1); end
    checks++; if (busy_bad !== 0) begin failures++; $display("FAIL full_busy: got %0d bad cycles want 0", busy_bad); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_grant_stalls();
    run_xfer(1'b0, 14'h0100, 1, 0, 0, 256);
    checks++; if (wa.size() !== 256) begin failures++; $display("FAIL stall_count: got %0d want 256", wa.size()); end
    checks++; if (order_errors(14'h0100) !== 0) begin failures++; $display("FAIL stall_order: got %0d bad words want 0", order_errors(14'h0100)); end
    checks++; if (done_cyc - 1 !== 256 + lows + 1) begin failures++; $display("FAIL stall_total_cycles: got %0d want %0d", done_cyc - 1, 256 + lows + 1); end
    checks++; if (we_nogt !== 0) begin failures++; $display("FAIL stall_we_without_gnt: got %0d want 0", we_nogt); end
  endtask

  task automatic test_late_grant();
    run_xfer(1'b0, 14'h0100, 2, 0, 0, 256);
    checks++; if (late_bad !== 0) begin failures++; $display("FAIL late_idle_cycles: got %0d bad want 0", late_bad); end
    checks++; if (first_wc() !== 12) begin failures++; $display("FAIL late_first_write: got cycle %0d want 12", first_wc()); end
    checks++; if (wa.size() == 0 || wa[0] !== 14'h0100) begin failures++; $display("FAIL late_first_addr: got %0d writes want addr 0100 first", wa.size()); end
    checks++; if (done_cyc !== 268) begin failures++; $display("FAIL late_done_cycle: got %0d want 268", done_cyc); end
  endtask

  task automatic test_start_while_busy();
    run_xfer(1'b0, 14'h0100, 0, 50, 0, 256);
    checks++; if (order_errors(14'h0100) !== 0 || wa.size() !== 256) begin failures++; $display("FAIL busy_start_order: got %0d bad of %0d want 0 of 256", order_errors(14'h0100), wa.size()); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL busy_start_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int extra_done = 0;
    logic [13:0] b2;
    run_xfer(1'b0, 14'h0100, 0, 0, 100, 256);
    checks++; if (wa.size() !== 100 || order_errors(14'h0100) !== 0) begin failures++; $display("FAIL rst_mid_prefix: got %0d writes %0d bad want 100 0", wa.size(), order_errors(14'h0100)); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || bus.spram_req !== 1'b0 || bus.spram_we !== 1'b0) begin failures++; $display("FAIL rst_mid_outputs: got busy=%b req=%b we=%b want 0 0 0", busy, bus.spram_req, bus.spram_we); end
    if (done) extra_done++;
    repeat (5) begin @(posedge clk); #2; if (done) extra_done++; end
    checks++; if (extra_done !== 0) begin failures++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", extra_done); end
    b2 = 14'($urandom);
    run_xfer(1'b0, b2, 0, 0, 0, 256);
    checks++; if (wa.size() !== 256 || order_errors(b2) !== 0) begin failures++; $display("FAIL rst_mid_reload: got %0d writes %0d bad want 256 0", wa.size(), order_errors(b2)); end
    checks++; if (done_cyc !== 258) begin failures++; $display("FAIL rst_mid_reload_done: got %0d want 258", done_cyc); end
  endtask

  task automatic test_random_stalls();
    for (int k = 0; k < 2; k++) begin
      logic [13:0] b;
      b = 14'($urandom);
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      run_xfer(1'b0, b, 3, 0, 0, 256);
      checks++; if (wa.size() !== 256 || order_errors(b) !== 0) begin failures++; $display("FAIL rand_order[%0d]: got %0d writes %0d bad want 256 0", k, wa.size(), order_errors(b)); end
      checks++; if (done_cyc - 1 !== 256 + lows + 1) begin failures++; $display("FAIL rand_total_cycles[%0d]: got %0d want %0d", k, done_cyc - 1, 256 + lows + 1); end
      checks++; if (we_nogt !== 0 || rd_oob !== 0) begin failures++; $display("FAIL rand_gating[%0d]: got we_nogt=%0d rd_oob=%0d want 0 0", k, we_nogt, rd_oob); end
    end
  endtask

  task automatic test_wrap_short();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    run_xfer(1'b1, 14'h3FFE, 0, 0, 0, 4);
    checks++; if (wa.size() !== 4) begin failures++; $display("FAIL wrap_count: got %0d want 4", wa.size()); end
    checks++; if (order_errors(14'h3FFE) !== 0) begin failures++; $display("FAIL wrap_order: got %0d bad words want 0", order_errors(14'h3FFE)); end
    checks++; if (done_cyc !== 6 || done_cnt !== 1) begin failures++; $display("FAIL wrap_done: got cycle %0d count %0d want 6 1", done_cyc, done_cnt); end
    checks++; if (rd_oob !== 0) begin failures++; $display("FAIL wrap_read_range: got %0d reads beyond count want 0", rd_oob); end
  endtask

  task automatic test_back_to_back();
    int dseen = -1;
    int wdone = -1;
    for (int i = 0; i < 4; i++) mem[i] = 16'($urandom);
    gnt = 1'b1;
    @(posedge clk); #1;
    base = 14'h0020; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      #1;
      if (done4) begin dseen = c; break; end
      @(posedge clk); #1;
    end
    checks++; if (dseen !== 6) begin failures++; $display("FAIL b2b_first_done: got cycle %0d want 6", dseen); end
    start4 = 1'b1; base = 14'h3000;
    @(posedge clk); #1;
    base = 14'h0030;
    #1;
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL b2b_done_cycle_start: got busy=%b want 0", busy4); end
    @(posedge clk); #1;
    start4 = 1'b0;
    #1;
    checks++; if (busy4 !== 1'b1) begin failures++; $display("FAIL b2b_accept_after_done: got busy=%b want 1", busy4); end
    wa.delete(); wd.delete(); wc.delete();
    for (int c = 0; c < 50; c++) begin
      if (bus4.spram_we) begin wa.push_back(bus4.spram_addr); wd.push_back(bus4.spram_wdata); end
      if (done4) begin wdone = c; break; end
      @(posedge clk); #2;
    end
    checks++; if (wa.size() !== 4 || order_errors(14'h0030) !== 0) begin failures++; $display("FAIL b2b_second_load: got %0d writes %0d bad want 4 0", wa.size(), order_errors(14'h0030)); end
    checks++; if (wdone < 0) begin failures++; $display("FAIL b2b_second_done: got %0d want done seen", wdone); end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_grant_stalls();
    test_late_grant();
    test_start_while_busy();
    test_reset_mid();
    test_random_stalls();
    test_wrap_short();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
